// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot path: arbiter state encoding,
// default screen bounds and the coordinate/colour field widths.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int C_W       = 3;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around).
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    hi    = req & mask;
    valid = |req;
    // x & -x isolates the lowest set bit
    if (|hi) winner = hi & (~hi + N'(1));
    else     winner = req & (~req + N'(1));
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one vga_adapter plot port among NUM_REQ clients;
// owner's plot reaches vga_* one cycle later, hand-over costs a GAP plus an IDLE cycle.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [NUM_REQ-1:0][X_W-1:0]   cl_x,
  input  logic [NUM_REQ-1:0][Y_W-1:0]   cl_y,
  input  logic [NUM_REQ-1:0][C_W-1:0]   cl_colour,
  input  logic [NUM_REQ-1:0]            cl_plot,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [C_W-1:0]                vga_colour,
  output logic                          vga_plot,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    owner;
  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic                in_range;

  rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_oh),
    .valid  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  assign in_range = (32'(cl_x[owner]) < X_MAX) && (32'(cl_y[owner]) < Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= OWN;
          end
        end
        OWN: begin
          // plot is sampled even on the release cycle so the last pixel is kept
          if (cl_plot[owner]) begin
            if (in_range) begin
              vga_x      <= cl_x[owner];
              vga_y      <= cl_y[owner];
              vga_colour <= cl_colour[owner];
              vga_plot   <= 1'b1;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
          if (!req[owner]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          if (owner == PTR_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                              rr_ptr <= owner + PTR_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter (NUM_REQ=3, 160x120).
module tb_vga_plot_arbiter;

  logic            clk;
  logic            rst_n;
  logic [2:0]      req;
  logic [2:0]      gnt;
  logic [2:0][7:0] cl_x;
  logic [2:0][6:0] cl_y;
  logic [2:0][2:0] cl_colour;
  logic [2:0]      cl_plot;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;
  logic            busy;
  logic [15:0]     drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  vga_plot_arbiter #(.NUM_REQ(3), .X_MAX(160), .Y_MAX(120)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .cl_x       (cl_x),
    .cl_y       (cl_y),
    .cl_colour  (cl_colour),
    .cl_plot    (cl_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    int exp_own;
    int nxt;
    rst_n     = 1'b0;
    req       = '0;
    cl_x      = '0;
    cl_y      = '0;
    cl_colour = '0;
    cl_plot   = '0;

    // reset state
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    step();
    rst_n = 1'b1;

    // single client grant and plot forwarding
    req = 3'b001;
    step();
    check("t1_gnt", gnt, 3'b001);
    check("t1_busy", busy, 1);
    cl_x[0] = 8'd5; cl_y[0] = 7'd7; cl_colour[0] = 3'b100; cl_plot[0] = 1'b1;
    step();
    check("t1_plot", vga_plot, 1);
    check("t1_x", vga_x, 5);
    check("t1_y", vga_y, 7);
    check("t1_col", vga_colour, 3'b100);
    cl_plot = '0;
    step();
    check("t1_plot_off", vga_plot, 0);
    check("t1_x_hold", vga_x, 5);
    // release and plot in the same cycle: plot still forwarded
    req = 3'b000;
    cl_x[0] = 8'd10; cl_y[0] = 7'd11; cl_colour[0] = 3'b010; cl_plot[0] = 1'b1;
    step();
    check("t1_rel_gnt", gnt, 0);
    check("t1_rel_busy", busy, 0);
    check("t1_rel_plot", vga_plot, 1);
    check("t1_rel_x", vga_x, 10);
    cl_plot = '0;
    step();
    check("t1_gap_plot", vga_plot, 0);
    do_reset();

    // round-robin 0,1,2,0 with all clients requesting
    req = 3'b111;
    step();
    for (int k = 0; k < 3; k++) begin
      exp_own = k;
      nxt     = (k + 1) % 3;
      check("rr_gnt", gnt, 32'(1) << exp_own);
      for (int j = 0; j < 4; j++) begin
        cl_x[exp_own] = 8'(10 * exp_own + j);
        cl_y[exp_own] = 7'(j);
        cl_plot = 3'b000;
        cl_plot[exp_own] = 1'b1;
        step();
        check("rr_plot_x", vga_x, 10 * exp_own + j);
      end
      cl_plot = '0;
      req[exp_own] = 1'b0;
      step();
      check("rr_gap_gnt", gnt, 0);
      req[exp_own] = 1'b1;
      step();
      check("rr_idle_gnt", gnt, 0);
      step();
      check("rr_next_gnt", gnt, 32'(1) << nxt);
    end
    check("rr_drop", drop_count, 0);

    // hand client0 over to client1
    req = 3'b010;
    step();
    step();
    step();
    check("t3_gnt", gnt, 3'b010);

    // non-owner plots ignored, grant locked
    req = 3'b110;
    cl_x[2] = 8'd3; cl_y[2] = 7'd3; cl_plot = 3'b100;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t3_plot", vga_plot, 0);
      check("t3_lock", gnt, 3'b010);
    end

    // out-of-range filtering
    cl_plot = 3'b010;
    cl_x[1] = 8'd160; cl_y[1] = 7'd0; cl_colour[1] = 3'b011;
    step();
    check("t4_drop_x", vga_plot, 0);
    check("t4_hold_x", vga_x, 23);
    cl_x[1] = 8'd0; cl_y[1] = 7'd120;
    step();
    check("t4_drop_y", vga_plot, 0);
    cl_x[1] = 8'd159; cl_y[1] = 7'd119;
    step();
    check("t4_edge_plot", vga_plot, 1);
    check("t4_edge_x", vga_x, 159);
    check("t4_edge_y", vga_y, 119);
    check("t4_edge_col", vga_colour, 3'b011);
    check("t4_drop_cnt", drop_count, 2);

    // move ownership to client2 so rr_ptr is non-zero before reset
    cl_plot = '0;
    req = 3'b100;
    step();
    step();
    step();
    check("t5_gnt2", gnt, 3'b100);
    cl_x[2] = 8'd20; cl_y[2] = 7'd30; cl_plot = 3'b100;
    step();
    check("t5_plot", vga_plot, 1);
    check("t5_x", vga_x, 20);
    req = 3'b111;
    cl_x[0] = 8'd1; cl_y[0] = 7'd1; cl_colour[0] = 3'b101;
    cl_plot = 3'b111;
    #3 rst_n = 1'b0;
    #1;
    check("t5_arst_gnt", gnt, 0);
    check("t5_arst_plot", vga_plot, 0);
    check("t5_arst_x", vga_x, 0);
    check("t5_arst_y", vga_y, 0);
    check("t5_arst_col", vga_colour, 0);
    check("t5_arst_busy", busy, 0);
    check("t5_arst_drop", drop_count, 0);
    #2 rst_n = 1'b1;
    step();
    check("t5_post_gnt", gnt, 3'b001);
    check("t5_post_plot", vga_plot, 0);
    step();
    check("t5_own_plot", vga_plot, 1);
    check("t5_own_x", vga_x, 1);

    // drop_count saturation
    cl_x[0] = 8'd200;
    repeat (65534) step();
    check("t6_drop_fffe", drop_count, 16'hFFFE);
    check("t6_plot", vga_plot, 0);
    repeat (70000 - 65534) step();
    check("t6_drop_sat", drop_count, 16'hFFFF);
    check("t6_x_hold", vga_x, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
